intersection_controller: RTL and testbench
==========================================

Name: intersection_controller

Overview:
- Master sequencer for a two-road (NS/EW) intersection; sits directly upstream of pedestrian_light.
- Runs the vehicle phase FSM and owns the 7-bit master countdown (master_timer).
- Latches pedestrian push-button requests and drives the per-direction walk enables that each pedestrian_light instance consumes.
- Timing advances on a 1 Hz strobe, so clk may be fast.

Parameters:
- GREEN_TIME, 40, seconds of green per direction; legal range 1..127.
- YELLOW_TIME, 4, seconds of yellow; legal range 1..127.
- ALL_RED_TIME, 2, seconds of all-red clearance between directions; legal range 1..127.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- sec_tick  input  1  one-cycle strobe, once per second.
- ped_button_ns  input  1  pedestrian request to cross alongside NS traffic; level, sampled every clk.
- ped_button_ew  input  1  same, alongside EW traffic.
- emergency  input  1  preemption request; present only with EMERGENCY_PREEMPT_EN.
- ns_light  output  3  one-hot {red,yellow,green}.
- ew_light  output  3  one-hot {red,yellow,green}.
- master_timer  output  7  seconds remaining in current phase; feeds pedestrian_light.
- ped_enable_ns  output  1  walk enable to NS pedestrian_light.
- ped_enable_ew  output  1  walk enable to EW pedestrian_light.

Behaviour:
- Clock and reset: single clock clk; reset_n synchronous active-low. All outputs are registered.
- Reset values: state ALL_RED_B; master_timer=ALL_RED_TIME; ns_light=ew_light=RED (3'b100); ped_enable_ns=ped_enable_ew=0; both request latches cleared. Reset mid-phase aborts immediately at the next edge.
- FSM states and their lights:
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - ALL_RED_A: both red.
  - EW_GREEN: EW green, NS red.
  - EW_YELLOW: EW yellow, NS red.
  - ALL_RED_B: both red.
- Sequence: NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN.
- Timer:
  - On phase entry, load the phase duration.
  - On sec_tick with master_timer>1, decrement by 1.
  - On sec_tick with master_timer==1, advance state and load the next duration in the same edge.
  - master_timer never reads 0. No sec_tick means no change.
- Request latch (per direction):
  - Set by a button-high sample.
  - Cleared when that direction's green is entered.
  - Button high on the entry edge itself is served, and the latch ends cleared.
  - Presses while that direction's walk is active are ignored; they do not latch for the next cycle.
  - Presses during that direction's green when walk is not active do latch, and are served next cycle.
- Walk enable:
  - Set on entry to a direction's green if its latch (or the same-edge button) is set.
  - Held for the whole green; cleared on exit to yellow.
  - Never asserted outside that direction's green.
  - ped_enable_ns and ped_enable_ew are never both 1.
- Safety invariant: ns_light and ew_light are never both non-red.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- Defined:
  - The emergency port exists.
  - emergency=1 in a GREEN state jumps to that direction's YELLOW with a full YELLOW_TIME load.
  - emergency=1 in a YELLOW state continues normally.
  - Entering ALL_RED_A or ALL_RED_B while emergency=1 goes to PREEMPT_HOLD: both red, walk enables 0, master_timer frozen at 127.
  - On emergency=0, PREEMPT_HOLD goes to ALL_RED_B with ALL_RED_TIME loaded.
  - Request latches persist across preemption.
- Undefined: the port is absent, and the PREEMPT_HOLD state and its logic are not compiled.

Decomposition:
- intersection_pkg holds:
  - phase state encoding (including PREEMPT_HOLD);
  - light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001;
  - the 7-bit timer width constant and the 127 hold value.
- One sub-module, phase_timer: 7-bit loadable down-counter with load, load_value, tick inputs and an expire (==1 and tick) output.
- The FSM and request latches stay in the top.

Test Plan:
- Reset, then 2 sec_ticks:
  - Before the ticks: RED/RED, master_timer 2->1, enables 0.
  - After tick 2: NS green, master_timer=40.
- Full cycle with no buttons: phase order and durations 40/4/2/40/4/2 ticks; walk enables stay 0; lights never both non-red.
- Press ped_button_ns one cycle during EW_GREEN:
  - ped_enable_ns=1 for all 40 seconds of the next NS_GREEN (master_timer 40..1).
  - Drops with the NS yellow.
- Press ped_button_ew during EW_GREEN with walk active: no walk in the following EW_GREEN.
- Button high on the exact edge of ALL_RED_B->NS_GREEN: walk served; latch cleared.
- Emergency (EMERGENCY_PREEMPT_EN build):
  - Asserted at NS_GREEN master_timer=25: NS_YELLOW with timer 4, then PREEMPT_HOLD with timer 127 and both red.
  - On release: ALL_RED_B, timer 2.

Source files
------------

// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared types and constants for the intersection controller
//   phase_e    : vehicle phase encoding, PREEMPT_HOLD included
//   light_t    : one-hot {red,yellow,green} lamp code
//   TIMER_W    : master countdown width; HOLD_VALUE is the frozen preemption count
package intersection_pkg;

  localparam int TIMER_W = 7;
  localparam logic [TIMER_W-1:0] HOLD_VALUE = 7'd127;

  typedef logic [2:0] light_t;
  localparam light_t RED    = 3'b100;
  localparam light_t YELLOW = 3'b010;
  localparam light_t GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN     = 3'd0,
    NS_YELLOW    = 3'd1,
    ALL_RED_A    = 3'd2,
    EW_GREEN     = 3'd3,
    EW_YELLOW    = 3'd4,
    ALL_RED_B    = 3'd5,
    PREEMPT_HOLD = 3'd6
  } phase_e;

  function automatic light_t ns_light_of(input phase_e p);
    case (p)
      NS_GREEN:  return GREEN;
      NS_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  function automatic light_t ew_light_of(input phase_e p);
    case (p)
      EW_GREEN:  return GREEN;
      EW_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// rtl/intersection_controller_if.sv - request/lamp/timer bundle between sequencer and its environment
//   master : drives sec_tick, ped_button_ns/ew (and emergency), observes lamps, timer, walk enables
//   slave  : the controller side
//   emergency exists only when EMERGENCY_PREEMPT_EN is defined
interface intersection_controller_if;
  import intersection_pkg::*;

  logic               sec_tick;
  logic               ped_button_ns;
  logic               ped_button_ew;
`ifdef EMERGENCY_PREEMPT_EN
  logic               emergency;
`endif
  light_t             ns_light;
  light_t             ew_light;
  logic [TIMER_W-1:0] master_timer;
  logic               ped_enable_ns;
  logic               ped_enable_ew;

  modport master (
    output sec_tick, ped_button_ns, ped_button_ew,
`ifdef EMERGENCY_PREEMPT_EN
    output emergency,
`endif
    input  ns_light, ew_light, master_timer, ped_enable_ns, ped_enable_ew
  );

  modport slave (
    input  sec_tick, ped_button_ns, ped_button_ew,
`ifdef EMERGENCY_PREEMPT_EN
    input  emergency,
`endif
    output ns_light, ew_light, master_timer, ped_enable_ns, ped_enable_ew
  );

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable 7-bit seconds down-counter that never reaches zero
//   clk, reset_n   : clock, synchronous active-low reset (count returns to RESET_VALUE)
//   load_i         : load load_value_i this edge (wins over tick_i)
//   tick_i         : one-second strobe
//   count_o        : seconds remaining
//   expire_o       : tick_i while count is 1; the owner must load the next duration
module phase_timer import intersection_pkg::*; #(
  parameter logic [TIMER_W-1:0] RESET_VALUE = 7'd1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_value_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (tick_i && (count_q > 7'd1)) begin
      count_d = count_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == 7'd1);

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - NS/EW vehicle phase sequencer with pedestrian request latches
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : sec_tick, ped_button_ns/ew in; ns_light, ew_light, master_timer,
//                  ped_enable_ns/ew out (all outputs registered)
//   EMERGENCY_PREEMPT_EN : adds the emergency input and the PREEMPT_HOLD phase
module intersection_controller import intersection_pkg::*; #(
  parameter int GREEN_TIME   = 40,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  intersection_controller_if.slave   bus
);

  localparam logic [TIMER_W-1:0] GREEN_T   = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] YELLOW_T  = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] ALL_RED_T = TIMER_W'(ALL_RED_TIME);

  phase_e             state_q, state_d;
  logic               load;
  logic [TIMER_W-1:0] load_value;
  logic               timer_tick;
  logic               expire;
  logic [TIMER_W-1:0] timer;

  logic   req_ns_q, req_ns_d, req_ew_q, req_ew_d;
  logic   walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  light_t ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic   enter_ns, enter_ew;

  // The hold count stays pinned at HOLD_VALUE, so seconds are not counted there.
`ifdef EMERGENCY_PREEMPT_EN
  assign timer_tick = bus.sec_tick && (state_q != PREEMPT_HOLD);
`else
  assign timer_tick = bus.sec_tick;
`endif

  phase_timer #(.RESET_VALUE(ALL_RED_T)) u_phase_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (load),
    .load_value_i (load_value),
    .tick_i       (timer_tick),
    .count_o      (timer),
    .expire_o     (expire)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_value = '0;
    case (state_q)
      NS_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (bus.emergency) begin
          state_d    = NS_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_T;
        end else
`endif
        if (expire) begin
          state_d    = NS_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_T;
        end
      end
      NS_YELLOW: begin
        if (expire) begin
          state_d    = ALL_RED_A;
          load       = 1'b1;
          load_value = ALL_RED_T;
`ifdef EMERGENCY_PREEMPT_EN
          if (bus.emergency) begin
            state_d    = PREEMPT_HOLD;
            load_value = HOLD_VALUE;
          end
`endif
        end
      end
      ALL_RED_A: begin
        if (expire) begin
          state_d    = EW_GREEN;
          load       = 1'b1;
          load_value = GREEN_T;
        end
      end
      EW_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (bus.emergency) begin
          state_d    = EW_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_T;
        end else
`endif
        if (expire) begin
          state_d    = EW_YELLOW;
          load       = 1'b1;
          load_value = YELLOW_T;
        end
      end
      EW_YELLOW: begin
        if (expire) begin
          state_d    = ALL_RED_B;
          load       = 1'b1;
          load_value = ALL_RED_T;
`ifdef EMERGENCY_PREEMPT_EN
          if (bus.emergency) begin
            state_d    = PREEMPT_HOLD;
            load_value = HOLD_VALUE;
          end
`endif
        end
      end
      ALL_RED_B: begin
        if (expire) begin
          state_d    = NS_GREEN;
          load       = 1'b1;
          load_value = GREEN_T;
        end
      end
`ifdef EMERGENCY_PREEMPT_EN
      PREEMPT_HOLD: begin
        if (!bus.emergency) begin
          state_d    = ALL_RED_B;
          load       = 1'b1;
          load_value = ALL_RED_T;
        end
      end
`endif
      default: begin
        // Unreachable encodings recover to the clearance phase before NS green.
        state_d    = ALL_RED_B;
        load       = 1'b1;
        load_value = ALL_RED_T;
      end
    endcase
  end

  // A press on the green-entry edge is served directly, so the latch ends cleared.
  // While a walk is showing, that direction's presses are dropped rather than queued.
  always_comb begin
    enter_ns   = (state_d == NS_GREEN) && (state_q != NS_GREEN);
    enter_ew   = (state_d == EW_GREEN) && (state_q != EW_GREEN);
    req_ns_d   = enter_ns ? 1'b0 : (req_ns_q | (bus.ped_button_ns & ~walk_ns_q));
    req_ew_d   = enter_ew ? 1'b0 : (req_ew_q | (bus.ped_button_ew & ~walk_ew_q));
    walk_ns_d  = enter_ns ? (req_ns_q | bus.ped_button_ns) : (walk_ns_q & (state_d == NS_GREEN));
    walk_ew_d  = enter_ew ? (req_ew_q | bus.ped_button_ew) : (walk_ew_q & (state_d == EW_GREEN));
    ns_light_d = ns_light_of(state_d);
    ew_light_d = ew_light_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ALL_RED_B;
      req_ns_q   <= 1'b0;
      req_ew_q   <= 1'b0;
      walk_ns_q  <= 1'b0;
      walk_ew_q  <= 1'b0;
      ns_light_q <= RED;
      ew_light_q <= RED;
    end else begin
      state_q    <= state_d;
      req_ns_q   <= req_ns_d;
      req_ew_q   <= req_ew_d;
      walk_ns_q  <= walk_ns_d;
      walk_ew_q  <= walk_ew_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
    end
  end

  assign bus.ns_light      = ns_light_q;
  assign bus.ew_light      = ew_light_q;
  assign bus.master_timer  = timer;
  assign bus.ped_enable_ns = walk_ns_q;
  assign bus.ped_enable_ew = walk_ew_q;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - self-checking bench for intersection_controller
module tb_intersection_controller;
  import intersection_pkg::*;

  localparam int G  = 40;
  localparam int Y  = 4;
  localparam int AR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  intersection_controller_if bus();

  intersection_controller #(
    .GREEN_TIME   (G),
    .YELLOW_TIME  (Y),
    .ALL_RED_TIME (AR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase index 0..5 walks NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B.
  int     dur[6]    = '{G, Y, AR, G, Y, AR};
  light_t ns_tab[6] = '{GREEN, YELLOW, RED, RED, RED, RED};
  light_t ew_tab[6] = '{RED, RED, RED, GREEN, YELLOW, RED};
  int     green_ph[2] = '{0, 3};
  int     m_ph, m_rem;
  bit     m_lat[2], m_walk[2];

  typedef struct {
    bit     tick, bns, bew;
    light_t ns, ew;
    int     tmr;
    bit     pns, pew;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = 5; m_rem = AR;
    m_lat[0] = 0; m_lat[1] = 0; m_walk[0] = 0; m_walk[1] = 0;
  endfunction

  function automatic void model_step(input bit tick, input bit bns, input bit bew);
    bit b[2];
    bit old_walk[2];
    bit entered;
    b[0] = bns; b[1] = bew;
    old_walk = m_walk;
    entered = 0;
    if (tick) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_ph = (m_ph + 1) % 6;
        m_rem = dur[m_ph];
        entered = 1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (entered && m_ph == green_ph[d]) begin
        m_walk[d] = m_lat[d] | b[d];
        m_lat[d] = 0;
      end else begin
        if (m_ph != green_ph[d]) m_walk[d] = 0;
        if (b[d] && !old_walk[d]) m_lat[d] = 1;
      end
    end
  endfunction

  task automatic check_model();
    chk("ns_light", int'(bus.ns_light), int'(ns_tab[m_ph]));
    chk("ew_light", int'(bus.ew_light), int'(ew_tab[m_ph]));
    chk("master_timer", int'(bus.master_timer), m_rem);
    chk("ped_enable_ns", int'(bus.ped_enable_ns), int'(m_walk[0]));
    chk("ped_enable_ew", int'(bus.ped_enable_ew), int'(m_walk[1]));
    chk("safety_both_nonred", int'(bus.ns_light != RED && bus.ew_light != RED), 0);
  endtask

  task automatic edge_in(input bit tick, input bit bns, input bit bew);
    bus.sec_tick = tick; bus.ped_button_ns = bns; bus.ped_button_ew = bew;
    @(posedge clk);
    #1;
    bus.sec_tick = 0; bus.ped_button_ns = 0; bus.ped_button_ew = 0;
  endtask

  task automatic step(input bit tick, input bit bns, input bit bew);
    edge_in(tick, bns, bew);
    model_step(tick, bns, bew);
    check_model();
  endtask

  task automatic goto_phase(input int ph, input int rem);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_ph == ph && m_rem == rem) begin ok = 1; break; end
      step(1, 0, 0);
    end
    if (!ok) chk("goto_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    bus.sec_tick = 0; bus.ped_button_ns = 0; bus.ped_button_ew = 0;
`ifdef EMERGENCY_PREEMPT_EN
    bus.emergency = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    chk("reset_ns_light", int'(bus.ns_light), int'(RED));
    chk("reset_ew_light", int'(bus.ew_light), int'(RED));
    chk("reset_timer", int'(bus.master_timer), AR);
    chk("reset_pns", int'(bus.ped_enable_ns), 0);
    chk("reset_pew", int'(bus.ped_enable_ew), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_dur[6];
    exp_dur = '{G, Y, AR, G, Y, AR};

    tbl[0] = '{0, 0, 0, RED,   RED, 2,  0, 0};
    tbl[1] = '{1, 0, 0, RED,   RED, 1,  0, 0};
    tbl[2] = '{0, 1, 0, RED,   RED, 1,  0, 0};
    tbl[3] = '{1, 0, 0, GREEN, RED, 40, 1, 0};
    tbl[4] = '{1, 1, 0, GREEN, RED, 39, 1, 0};
    tbl[5] = '{1, 0, 1, GREEN, RED, 38, 1, 0};
    tbl[6] = '{0, 0, 0, GREEN, RED, 38, 1, 0};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].tick, tbl[i].bns, tbl[i].bew);
      chk($sformatf("tbl%0d_ns", i), int'(bus.ns_light), int'(tbl[i].ns));
      chk($sformatf("tbl%0d_ew", i), int'(bus.ew_light), int'(tbl[i].ew));
      chk($sformatf("tbl%0d_tmr", i), int'(bus.master_timer), tbl[i].tmr);
      chk($sformatf("tbl%0d_pns", i), int'(bus.ped_enable_ns), int'(tbl[i].pns));
      chk($sformatf("tbl%0d_pew", i), int'(bus.ped_enable_ew), int'(tbl[i].pew));
    end

    // EW request latched during NS green is served at EW green entry.
    goto_phase(3, G);
    chk("ew_walk_served", int'(bus.ped_enable_ew), 1);
    step(1, 0, 1);
    step(0, 1, 0);

    // NS walk held for the entire next NS green, dropping with yellow.
    goto_phase(0, G);
    for (int i = 0; i < G; i++) begin
      chk("ns_walk_timer", int'(bus.master_timer), G - i);
      chk("ns_walk_held", int'(bus.ped_enable_ns), 1);
      step(1, 0, 0);
    end
    chk("ns_walk_drop_light", int'(bus.ns_light), int'(YELLOW));
    chk("ns_walk_drop_timer", int'(bus.master_timer), Y);
    chk("ns_walk_drop", int'(bus.ped_enable_ns), 0);

    // Press while EW walk was active must not carry over.
    goto_phase(3, G);
    chk("ew_press_ignored", int'(bus.ped_enable_ew), 0);

    // Full cycle, no buttons: phase durations measured from lamp changes.
    for (int k = 0; k < 6; k++) begin
      light_t n0, e0;
      int n;
      n0 = bus.ns_light; e0 = bus.ew_light; n = 0;
      do begin
        step(1, 0, 0);
        n++;
      end while (bus.ns_light == n0 && bus.ew_light == e0 && n < 200);
      chk($sformatf("dur_%0d", k), n, exp_dur[k]);
    end

    // Button high exactly on the ALL_RED_B -> NS_GREEN edge.
    goto_phase(5, 1);
    step(1, 1, 0);
    chk("edge_press_served", int'(bus.ped_enable_ns), 1);
    goto_phase(5, 1);
    step(1, 0, 0);
    chk("edge_press_latch_cleared", int'(bus.ped_enable_ns), 0);

`ifdef EMERGENCY_PREEMPT_EN
    goto_phase(0, 25);
    bus.emergency = 1;
    edge_in(0, 0, 0);
    bus.emergency = 1;
    chk("emg_to_yellow", int'(bus.ns_light), int'(YELLOW));
    chk("emg_yellow_timer", int'(bus.master_timer), Y);
    for (int i = 0; i < Y; i++) begin
      bus.emergency = 1;
      edge_in(1, 0, 0);
    end
    bus.emergency = 1;
    chk("emg_hold_ns", int'(bus.ns_light), int'(RED));
    chk("emg_hold_ew", int'(bus.ew_light), int'(RED));
    chk("emg_hold_timer", int'(bus.master_timer), 127);
    repeat (3) begin
      bus.emergency = 1;
      edge_in(1, 0, 0);
    end
    chk("emg_hold_frozen", int'(bus.master_timer), 127);
    chk("emg_hold_walk", int'(bus.ped_enable_ns | bus.ped_enable_ew), 0);
    bus.emergency = 0;
    edge_in(0, 0, 0);
    chk("emg_release_timer", int'(bus.master_timer), AR);
    chk("emg_release_ns", int'(bus.ns_light), int'(RED));
    edge_in(1, 0, 0);
    edge_in(1, 0, 0);
    chk("emg_resume_ns_green", int'(bus.ns_light), int'(GREEN));
    do_reset();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
